// File: rtl/stage_ctrl_writer.sv
// Control-plane writer for one match-action stage: assembles key/mask or action
// entries from 32-bit command words and issues a one-cycle write strobe.
module stage_ctrl_writer #(
  parameter int STAGE_ID = 0,
  parameter int KEY_LEN  = 896,
  parameter int MASK_LEN = 896,
  parameter int ACT_LEN  = 25,
  parameter int ADDR_W   = 4
) (
  input  logic                axis_clk,
  input  logic                areset,
  input  logic [31:0]         ctrl_data,
  input  logic                ctrl_valid,
  input  logic                ctrl_last,
  output logic                ctrl_ready,
  output logic [KEY_LEN-1:0]  lookup_din,
  output logic [MASK_LEN-1:0] lookup_din_mask,
  output logic [ADDR_W-1:0]   lookup_din_addr,
  output logic                lookup_din_en,
  output logic [ACT_LEN-1:0]  action_data_in,
  output logic [ADDR_W-1:0]   action_addr,
  output logic                action_en,
  output logic [15:0]         err_cnt
);

  localparam int KEY_WORDS  = KEY_LEN / 32;
  localparam int MASK_WORDS = MASK_LEN / 32;
  localparam int MAX_WORDS  = (KEY_WORDS > MASK_WORDS) ? KEY_WORDS : MASK_WORDS;
  localparam int CNT_W      = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_MASK, S_ACT, S_COMMIT_L, S_COMMIT_A, S_DROP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KEY_LEN-1:0]  key_sh_q, key_sh_d;
  logic [MASK_LEN-1:0] mask_sh_q, mask_sh_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [KEY_LEN-1:0]  lk_key_q, lk_key_d;
  logic [MASK_LEN-1:0] lk_mask_q, lk_mask_d;
  logic [ADDR_W-1:0]   lk_addr_q, lk_addr_d;
  logic [ACT_LEN-1:0]  act_data_q, act_data_d;
  logic [ADDR_W-1:0]   act_addr_q, act_addr_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                err_inc;
  logic                xfer;
  logic                stage_hit;
  logic [3:0]          opcode;

  // Ready is a pure function of state so it never depends on ctrl_valid.
  assign ctrl_ready = !areset && (state_q != S_COMMIT_L) && (state_q != S_COMMIT_A);
  assign xfer       = ctrl_valid && ctrl_ready;
  assign opcode     = ctrl_data[31:28];
  assign stage_hit  = (ctrl_data[27:24] == 4'(STAGE_ID));

  assign lookup_din      = lk_key_q;
  assign lookup_din_mask = lk_mask_q;
  assign lookup_din_addr = lk_addr_q;
  assign lookup_din_en   = (state_q == S_COMMIT_L);
  assign action_data_in  = act_data_q;
  assign action_addr     = act_addr_q;
  assign action_en       = (state_q == S_COMMIT_A);
  assign err_cnt         = err_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_sh_d   = key_sh_q;
    mask_sh_d  = mask_sh_q;
    addr_d     = addr_q;
    lk_key_d   = lk_key_q;
    lk_mask_d  = lk_mask_q;
    lk_addr_d  = lk_addr_q;
    act_data_d = act_data_q;
    act_addr_d = act_addr_q;
    err_inc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          addr_d = ctrl_data[ADDR_W-1:0];
          cnt_d  = '0;
          if (ctrl_last) begin
            err_inc = stage_hit;
          end else if (stage_hit && opcode == 4'd1) begin
            state_d = S_KEY;
          end else if (stage_hit && opcode == 4'd2) begin
            state_d = S_ACT;
          end else begin
            state_d = S_DROP;
            err_inc = stage_hit;
          end
        end
      end
      S_KEY: begin
        if (xfer) begin
          // First word ends up in the MSBs after the full shift sequence.
          key_sh_d = (key_sh_q << 32) | KEY_LEN'(ctrl_data);
          if (ctrl_last) begin
            state_d = S_IDLE;
            err_inc = 1'b1;
          end else if (cnt_q == CNT_W'(KEY_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = S_MASK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MASK: begin
        if (xfer) begin
          mask_sh_d = (mask_sh_q << 32) | MASK_LEN'(ctrl_data);
          if (cnt_q == CNT_W'(MASK_WORDS - 1)) begin
            cnt_d = '0;
            if (ctrl_last) begin
              state_d   = S_COMMIT_L;
              lk_key_d  = key_sh_q;
              lk_mask_d = mask_sh_d;
              lk_addr_d = addr_q;
            end else begin
              state_d = S_DROP;
              err_inc = 1'b1;
            end
          end else if (ctrl_last) begin
            state_d = S_IDLE;
            err_inc = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ACT: begin
        if (xfer) begin
          if (ctrl_last) begin
            state_d    = S_COMMIT_A;
            act_data_d = ctrl_data[ACT_LEN-1:0];
            act_addr_d = addr_q;
          end else begin
            state_d = S_DROP;
            err_inc = 1'b1;
          end
        end
      end
      S_COMMIT_L, S_COMMIT_A: state_d = S_IDLE;
      S_DROP: begin
        if (xfer && ctrl_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_cnt_d = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      key_sh_q   <= '0;
      mask_sh_q  <= '0;
      addr_q     <= '0;
      lk_key_q   <= '0;
      lk_mask_q  <= '0;
      lk_addr_q  <= '0;
      act_data_q <= '0;
      act_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_sh_q   <= key_sh_d;
      mask_sh_q  <= mask_sh_d;
      addr_q     <= addr_d;
      lk_key_q   <= lk_key_d;
      lk_mask_q  <= lk_mask_d;
      lk_addr_q  <= lk_addr_d;
      act_data_q <= act_data_d;
      act_addr_q <= act_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
